// File: rtl/rgb_filter_pkg.sv
// rgb_filter_pkg: mode codes, 3x3 window slot indices and luma weights for rgb_kernel_filter.
package rgb_filter_pkg;
  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_GRAY  = 2'd1;
  localparam logic [1:0] MODE_BLUR  = 2'd2;
  localparam logic [1:0] MODE_SHARP = 2'd3;
  localparam int NUM_SLOTS      = 9;
  localparam int SLOT_DOWNRIGHT = 0;
  localparam int SLOT_DOWNLEFT  = 1;
  localparam int SLOT_UPRIGHT   = 2;
  localparam int SLOT_UPLEFT    = 3;
  localparam int SLOT_DOWN      = 4;
  localparam int SLOT_UP        = 5;
  localparam int SLOT_RIGHT     = 6;
  localparam int SLOT_LEFT      = 7;
  localparam int SLOT_CENTRE    = 8;
  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;
endpackage

// File: rtl/kernel_channel_alu.sv
// kernel_channel_alu: one colour channel's blur/sharpen arithmetic (S2 register) and clamp (S3 register).
module kernel_channel_alu
  import rgb_filter_pkg::*;
#(
  parameter int CH_W = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic [NUM_SLOTS*CH_W-1:0]   slots,
  input  logic [CH_W-1:0]             alt,
  output logic [CH_W-1:0]             result,
  output logic                        clip
);
  localparam int RW = CH_W + 4;
  logic [RW:0] sum;
  logic signed [RW-1:0] blur, sharp, raw;
  logic neg, over;
  function automatic logic signed [RW-1:0] ext(input logic [CH_W-1:0] v);
    return signed'({4'b0, v});
  endfunction
  always_comb begin
    sum = (RW+1)'(4);
    for (int k = 0; k < NUM_SLOTS; k++) sum = sum + (RW+1)'(slots[k*CH_W +: CH_W]);
  end
  assign blur  = signed'(RW'(sum / (RW+1)'(9)));
  assign sharp = (ext(slots[SLOT_CENTRE*CH_W +: CH_W]) <<< 2) + ext(slots[SLOT_CENTRE*CH_W +: CH_W])
               - ext(slots[SLOT_UP*CH_W +: CH_W]) - ext(slots[SLOT_DOWN*CH_W +: CH_W])
               - ext(slots[SLOT_LEFT*CH_W +: CH_W]) - ext(slots[SLOT_RIGHT*CH_W +: CH_W]);
  // Headroom of 4 bits keeps 5*max and -4*max representable, so only sign and upper bits decide clipping.
  assign neg  = raw[RW-1];
  assign over = !neg && |raw[RW-2:CH_W];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      raw    <= '0;
      result <= '0;
      clip   <= 1'b0;
    end else if (en) begin
      raw    <= mode == MODE_BLUR ? blur : mode == MODE_SHARP ? sharp : ext(alt);
      result <= neg ? '0 : over ? '1 : raw[CH_W-1:0];
      clip   <= neg || over;
    end
endmodule

// File: rtl/rgb_kernel_filter.sv
// rgb_kernel_filter: 3-stage elastic 3x3 pixel filter (pass/gray/blur/sharpen) with clamping.
// Define RGB_KERNEL_FILTER_CLIP_CNT_EN to enable the saturating clip_count counter.
module rgb_kernel_filter
  import rgb_filter_pkg::*;
#(
  parameter int CH_W   = 4,
  parameter int NUM_CH = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9*NUM_CH*CH_W-1:0]      win_data,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*CH_W-1:0]        filter_out,
  output logic [NUM_CH*CH_W-1:0]        original_out,
  output logic [15:0]                   clip_count
);
  localparam int PW = NUM_CH * CH_W;
  logic en, v1, v2;
  logic [NUM_SLOTS*PW-1:0] win1;
  logic [1:0] mode1;
  logic [PW-1:0] centre1, orig2, filt;
  logic [NUM_CH-1:0] clips;
  logic [NUM_CH-1:0][CH_W-1:0] alt;
  logic [NUM_CH-1:0][NUM_SLOTS*CH_W-1:0] ch_slots;
  assign en         = out_ready || !out_valid;
  assign in_ready   = en;
  assign centre1    = win1[SLOT_CENTRE*PW +: PW];
  assign filter_out = filt;
  always_comb begin
    ch_slots = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < NUM_SLOTS; k++)
        ch_slots[c][k*CH_W +: CH_W] = win1[k*PW + c*CH_W +: CH_W];
  end
  generate
    if (NUM_CH == 3) begin : g_gray
      logic [CH_W+8:0] luma;
      assign luma = (CH_W+9)'(LUMA_R * centre1[2*CH_W +: CH_W] + LUMA_G * centre1[CH_W +: CH_W]
                            + LUMA_B * centre1[0 +: CH_W]);
      assign alt  = mode1 == MODE_GRAY ? {3{luma[CH_W+7:8]}} : centre1;
    end else begin : g_nogray
      assign alt = centre1;
    end
  endgenerate
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    kernel_channel_alu #(.CH_W(CH_W)) u_alu (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .mode   (mode1),
      .slots  (ch_slots[c]),
      .alt    (alt[c]),
      .result (filt[c*CH_W +: CH_W]),
      .clip   (clips[c])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1           <= 1'b0;
      win1         <= '0;
      mode1        <= MODE_PASS;
      v2           <= 1'b0;
      orig2        <= '0;
      out_valid    <= 1'b0;
      original_out <= '0;
    end else if (en) begin
      v1           <= in_valid;
      win1         <= win_data;
      mode1        <= mode;
      v2           <= v1;
      orig2        <= centre1;
      out_valid    <= v2;
      original_out <= orig2;
    end
`ifdef RGB_KERNEL_FILTER_CLIP_CNT_EN
  logic [16:0] cnt_next;
  assign cnt_next = {1'b0, clip_count} + 17'($countones(clips));
  always_ff @(posedge clk or posedge reset)
    if (reset) clip_count <= '0;
    else if (out_valid && out_ready) clip_count <= cnt_next[16] ? 16'hFFFF : cnt_next[15:0];
`else
  logic unused_clips;
  assign unused_clips = |clips;
  assign clip_count   = '0;
`endif
endmodule

// File: tb/tb_rgb_kernel_filter.sv
// tb_rgb_kernel_filter: directed checks of modes, latency, backpressure and mid-stream reset.
module tb_rgb_kernel_filter;
  localparam int CH_W = 4;
  localparam int NUM_CH = 3;
  localparam int PW = NUM_CH * CH_W;
`ifdef RGB_KERNEL_FILTER_CLIP_CNT_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  typedef struct {
    logic [1:0]    m;
    logic [PW-1:0] c;
    logic [PW-1:0] n;
    logic [PW-1:0] f;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9*PW-1:0] win_data = '0;
  logic [1:0] mode = 2'd0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [PW-1:0] filter_out, original_out;
  logic [15:0] clip_count;
  logic [15:0] exp_clip = '0;
  int checks = 0;
  int errors = 0;
  vec_t v[5];
  always #5 clk = ~clk;
  rgb_kernel_filter #(.CH_W(CH_W), .NUM_CH(NUM_CH)) dut (
    .clk          (clk),
    .reset        (reset),
    .win_data     (win_data),
    .mode         (mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .filter_out   (filter_out),
    .original_out (original_out),
    .clip_count   (clip_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [9*PW-1:0] win(input logic [PW-1:0] c, input logic [PW-1:0] n);
    return {c, {8{n}}};
  endfunction
  task automatic add_clip(input int n);
    exp_clip = exp_clip + (CLIP_EN ? 16'(n) : 16'd0);
  endtask
  task automatic run_one(input string tag, input logic [1:0] m, input logic [PW-1:0] c,
                         input logic [PW-1:0] n, input logic [PW-1:0] exp_f, input int clips);
    @(negedge clk);
    win_data = win(c, n);
    mode = m;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mode = ~m;
    win_data = '0;
    @(negedge clk);
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_filter"}, 32'(filter_out), 32'(exp_f));
    check({tag, "_orig"}, 32'(original_out), 32'(c));
    @(negedge clk);
    add_clip(clips);
    check({tag, "_clip"}, 32'(clip_count), 32'(exp_clip));
  endtask
  initial begin
    int acc = 0;
    int emi = 0;
    bit fell = 1'b0;
    bit stale = 1'b0;
    v[0] = '{2'd0, 12'h123, 12'h000, 12'h123};
    v[1] = '{2'd1, 12'hF00, 12'h000, 12'h444};
    v[2] = '{2'd3, 12'h321, 12'h111, 12'hB61};
    v[3] = '{2'd2, 12'h888, 12'h888, 12'h888};
    v[4] = '{2'd0, 12'hABC, 12'hFFF, 12'hABC};
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_filter", 32'(filter_out), 32'd0);
    check("rst_orig", 32'(original_out), 32'd0);
    check("rst_clip", 32'(clip_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    run_one("pass", 2'd0, 12'h5A3, 12'h123, 12'h5A3, 0);
    run_one("gray_r", 2'd1, 12'hF00, 12'h000, 12'h444, 0);
    run_one("gray_g", 2'd1, 12'h0F0, 12'h000, 12'h888, 0);
    run_one("gray_b", 2'd1, 12'h00F, 12'h000, 12'h111, 0);
    run_one("blur_flat", 2'd2, 12'h888, 12'h888, 12'h888, 0);
    run_one("blur_round", 2'd2, 12'hF92, 12'h000, 12'h210, 0);
    run_one("sharp_mid", 2'd3, 12'h321, 12'h111, 12'hB61, 0);
    run_one("sharp_hi", 2'd3, 12'hF0F, 12'h000, 12'hF0F, 2);
    run_one("sharp_lo", 2'd3, 12'h000, 12'hFFF, 12'h000, 3);
    for (int t = 0; t < 40 && emi < 5; t++) begin
      @(negedge clk);
      out_ready = !(t >= 1 && t < 7);
      in_valid = acc < 5;
      if (acc < 5) begin
        win_data = win(v[acc].c, v[acc].n);
        mode = v[acc].m;
      end
      #1;
      if (!in_ready && !fell) begin
        fell = 1'b1;
        check("bp_held", 32'(acc - emi), 32'd3);
      end
      if (out_valid && out_ready) begin
        check("bp_filter", 32'(filter_out), 32'(v[emi].f));
        check("bp_orig", 32'(original_out), 32'(v[emi].c));
        emi++;
      end
      if (in_valid && in_ready) acc++;
    end
    check("bp_fell", 32'(fell), 32'd1);
    check("bp_count", 32'(emi), 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_clip", 32'(clip_count), 32'(exp_clip));
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    win_data = win(12'hF0F, 12'h000);
    mode = 2'd3;
    @(negedge clk);
    win_data = win(12'h000, 12'hFFF);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mrst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    exp_clip = '0;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_filter", 32'(filter_out), 32'd0);
    check("mrst_orig", 32'(original_out), 32'd0);
    check("mrst_clip", 32'(clip_count), 32'(exp_clip));
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("mrst_stale", 32'(stale), 32'd0);
    check("mrst_clip_after", 32'(clip_count), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_kernel_filter.md
RGB_KERNEL_FILTER -- requirements
Module: rgb_kernel_filter

Interface
REQ-001 The block SHALL have parameter CH_W, default 4, giving bits per colour channel.
REQ-002 The block SHALL have parameter NUM_CH, default 3, giving channels per pixel (R most significant); PW = NUM_CH*CH_W.
REQ-003 The block SHALL have port clk, input, 1 bit, clock.
REQ-004 The block SHALL have port reset, input, 1 bit, reset: asynchronous, active-high.
REQ-005 The block SHALL have port win_data, input, 9*PW bits, 3x3 window; slot k at [k*PW +: PW]; k = 0 downright, 1 downleft, 2 upright, 3 upleft, 4 down, 5 up, 6 right, 7 left, 8 centre.
REQ-006 The block SHALL have port mode, input, 2 bits, filter select sampled with each accepted window.
REQ-007 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit), the input handshake.
REQ-008 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), the output handshake.
REQ-009 The block SHALL have port filter_out, output, PW bits, filtered centre pixel.
REQ-010 The block SHALL have port original_out, output, PW bits, unfiltered centre pixel aligned with filter_out.
REQ-011 The block SHALL have port clip_count, output, 16 bits, saturated-channel counter.

Function
REQ-012 Accept a window on in_valid && in_ready; emit on out_valid && out_ready.
REQ-013 3-stage elastic pipeline (S1 register window/mode, S2 arithmetic, S3 clamp/output); minimum latency 3 cycles from acceptance to out_valid.
REQ-014 Global advance enable = out_ready || !out_valid; in_ready equals that enable; bubbles propagate as valid=0; no window dropped or duplicated under backpressure.
REQ-015 Mode 0 passthrough: filter_out = centre.
REQ-016 Mode 1 grayscale (NUM_CH=3 only): Y = (77*R + 150*G + 29*B) >> 8, replicated to all channels; with NUM_CH≠3, mode 1 behaves as mode 0.
REQ-017 Mode 2 box blur, per channel: floor((sum of 9 slots + 4) / 9).
REQ-018 Mode 3 sharpen, per channel: 5*centre - up - down - left - right, signed, width CH_W+4.
REQ-019 Every channel result SHALL be clamped to [0, 2^CH_W-1]; each clamped channel is a clip event.
REQ-020 Mode travels with its window; a mode change mid-stream affects only windows accepted after it.
REQ-021 original_out SHALL be the centre slot of the same window as filter_out.

Reset
REQ-022 On reset: out_valid=0, filter_out=0, original_out=0, clip_count=0, all stage valids 0; in_ready=1 the first cycle after release.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight windows; out_valid=0 immediately.

Configuration
REQ-024 Macro RGB_KERNEL_FILTER_CLIP_CNT_EN defined: clip_count increments by the number of clip events of each emitted pixel (counted at output handshake), saturating at 0xFFFF.
REQ-025 Macro undefined: clip_count tied to 0, no counter logic.

Structure
REQ-026 Package rgb_filter_pkg SHALL hold mode constants (MODE_PASS, MODE_GRAY, MODE_BLUR, MODE_SHARP), slot-index constants and luma weights 77/150/29.
REQ-027 Per-channel blur/sharpen arithmetic and clamp SHALL be sub-module kernel_channel_alu, instantiated NUM_CH times; grayscale lives in the top.

Verification (CH_W=4, NUM_CH=3)
REQ-028 Mode 1, centre 0xF00, out_ready=1 -> filter_out 0x444, original_out 0xF00, 3 cycles after acceptance.
REQ-029 Mode 2, all nine slots 0x888 -> filter_out 0x888, clip_count unchanged.
REQ-030 Mode 3, centre 0xF0F, neighbours 0x000 -> filter_out 0xF0F, clip_count +2; centre 0x000, neighbours 0xFFF -> 0x000, clip_count +3.
REQ-031 Five back-to-back windows, out_ready low for 6 cycles -> in_ready falls once 3 windows are held; after release all 5 outputs appear in order, none lost.
REQ-032 Reset pulse with 2 windows in flight -> out_valid 0 at once, no stale output after release, clip_count 0.
